// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state encoding for the rx frame path
// Purpose: byte markers, price width, default timeout and sequencer state enum.
// Ports: none (package).
package arb_pkg;

    localparam logic [7:0] HDR_BYTE        = 8'hAA;
    localparam logic [7:0] FTR_BYTE        = 8'h55;
    localparam int         PRICE_W         = 16;
    localparam int         DEFAULT_TIMEOUT = 156250;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        A_HI = 3'd1,
        A_LO = 3'd2,
        B_HI = 3'd3,
        B_LO = 3'd4,
        FTR  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter
// Purpose: counts inc strobes, sticks at all-ones instead of wrapping.
// Ports: clk, rst (sync active-high), inc (count enable), count (W-bit value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rx_frame_sequencer.sv
// rtl/rx_frame_sequencer.sv - UART byte stream to price-pair commit sequencer
// Purpose: hunts 0xAA header, assembles big-endian prices A and B, checks the
//          0x55 footer, commits both prices in one strobe, aborts on timeout,
//          framing error or bad footer, keeps saturating health counters.
// Ports: clk, rst (sync active-high); rx_valid/rx_data/rx_ferr byte input;
//        engine_ready back-pressure; frame_valid/price_a/price_b commit;
//        in_frame, err_pulse status; cnt_ok/cnt_bad/cnt_drop counters.
module rx_frame_sequencer
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               rx_ferr,
    input  logic               engine_ready,
    output logic               frame_valid,
    output logic [PRICE_W-1:0] price_a,
    output logic [PRICE_W-1:0] price_b,
    output logic               in_frame,
    output logic               err_pulse,
    output logic [CNT_W-1:0]   cnt_ok,
    output logic [CNT_W-1:0]   cnt_bad,
    output logic [CNT_W-1:0]   cnt_drop
);

    // One extra count of headroom so the timer can hold TIMEOUT_CYCLES for the
    // single cycle between a timeout abort and re-entering HUNT.
    localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t         state;
    seq_state_t         nxt;
    logic [PRICE_W-1:0] shadow_a;
    logic [PRICE_W-1:0] shadow_b;
    logic [TW-1:0]      timer;
    logic               abort;
    logic               commit;
    logic               drop;

    always_comb begin
        nxt    = state;
        abort  = 1'b0;
        commit = 1'b0;
        drop   = 1'b0;
        if (state != HUNT) begin
            if (rx_valid) begin
                // A byte always beats a simultaneous timer expiry.
                if (rx_ferr) begin
                    abort = 1'b1;
                    nxt   = HUNT;
                end else begin
                    case (state)
                        A_HI: nxt = A_LO;
                        A_LO: nxt = B_HI;
                        B_HI: nxt = B_LO;
                        B_LO: nxt = FTR;
                        FTR: begin
                            if (rx_data == FTR_BYTE) begin
                                nxt = HUNT;
                                if (engine_ready) commit = 1'b1;
                                else              drop   = 1'b1;
                            end else if (rx_data == HDR_BYTE) begin
                                // Treat the stray header as the start of a new frame.
                                abort = 1'b1;
                                nxt   = A_HI;
                            end else begin
                                abort = 1'b1;
                                nxt   = HUNT;
                            end
                        end
                        default: nxt = HUNT;
                    endcase
                end
            end else if (timer == TIMER_LAST) begin
                abort = 1'b1;
                nxt   = HUNT;
            end
        end else if (rx_valid && !rx_ferr && (rx_data == HDR_BYTE)) begin
            nxt = A_HI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            in_frame    <= 1'b0;
            frame_valid <= 1'b0;
            err_pulse   <= 1'b0;
            price_a     <= '0;
            price_b     <= '0;
            shadow_a    <= '0;
            shadow_b    <= '0;
            timer       <= '0;
        end else begin
            state       <= nxt;
            in_frame    <= (nxt != HUNT);
            frame_valid <= commit;
            err_pulse   <= abort;
            timer       <= ((state == HUNT) || rx_valid) ? '0 : timer + 1'b1;
            if (rx_valid && !rx_ferr) begin
                case (state)
                    A_HI:    shadow_a[15:8] <= rx_data;
                    A_LO:    shadow_a[7:0]  <= rx_data;
                    B_HI:    shadow_b[15:8] <= rx_data;
                    B_LO:    shadow_b[7:0]  <= rx_data;
                    default: ;
                endcase
            end
            if (commit) begin
                price_a <= shadow_a;
                price_b <= shadow_b;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt_ok (
        .clk   (clk),
        .rst   (rst),
        .inc   (commit),
        .count (cnt_ok)
    );

    sat_counter #(.W(CNT_W)) u_cnt_bad (
        .clk   (clk),
        .rst   (rst),
        .inc   (abort),
        .count (cnt_bad)
    );

    sat_counter #(.W(CNT_W)) u_cnt_drop (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop),
        .count (cnt_drop)
    );

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// tb/tb_rx_frame_sequencer.sv - self-checking bench for rx_frame_sequencer
module tb_rx_frame_sequencer;

    localparam int T  = 40;
    localparam int CW = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ferr;
    logic          engine_ready;
    logic          frame_valid;
    logic [15:0]   price_a;
    logic [15:0]   price_b;
    logic          in_frame;
    logic          err_pulse;
    logic [CW-1:0] cnt_ok;
    logic [CW-1:0] cnt_bad;
    logic [CW-1:0] cnt_drop;

    rx_frame_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ferr      (rx_ferr),
        .engine_ready (engine_ready),
        .frame_valid  (frame_valid),
        .price_a      (price_a),
        .price_b      (price_b),
        .in_frame     (in_frame),
        .err_pulse    (err_pulse),
        .cnt_ok       (cnt_ok),
        .cnt_bad      (cnt_bad),
        .cnt_drop     (cnt_drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: number of frame bytes collected so far (0 = hunting),
    // the collected bytes, and silent cycles since the last byte.
    int         nb;
    int         idle;
    logic [7:0] fb [6];
    logic [15:0] m_pa, m_pb;
    int         m_ok, m_bad, m_drop;
    logic       m_fv, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
        chk("err_pulse",   {31'd0, err_pulse},   {31'd0, m_err});
        chk("in_frame",    {31'd0, in_frame},    (nb > 0) ? 32'd1 : 32'd0);
        chk("price_a",     {16'd0, price_a},     {16'd0, m_pa});
        chk("price_b",     {16'd0, price_b},     {16'd0, m_pb});
        chk("cnt_ok",      32'(cnt_ok),          32'(m_ok));
        chk("cnt_bad",     32'(cnt_bad),         32'(m_bad));
        chk("cnt_drop",    32'(cnt_drop),        32'(m_drop));
    endtask

    task automatic m_abort();
        m_err = 1'b1;
        if (m_bad < MAXC) m_bad++;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
        rx_valid     = v;
        rx_data      = d;
        rx_ferr      = f;
        engine_ready = r;
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (v) begin
            idle = 0;
            if (nb == 0) begin
                if (!f && d == 8'hAA) begin
                    fb[0] = d;
                    nb = 1;
                end
            end else if (f) begin
                m_abort();
                nb = 0;
            end else if (nb < 5) begin
                fb[nb] = d;
                nb++;
            end else if (d == 8'h55) begin
                if (r) begin
                    m_pa = {fb[1], fb[2]};
                    m_pb = {fb[3], fb[4]};
                    m_fv = 1'b1;
                    if (m_ok < MAXC) m_ok++;
                end else if (m_drop < MAXC) begin
                    m_drop++;
                end
                nb = 0;
            end else if (d == 8'hAA) begin
                m_abort();
                fb[0] = d;
                nb = 1;
            end else begin
                m_abort();
                nb = 0;
            end
        end else if (nb > 0) begin
            idle++;
            if (idle == T) begin
                m_abort();
                nb = 0;
                idle = 0;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        check_all();
    endtask

    task automatic byte_in(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b1);
    endtask

    task automatic quiet(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic frame(input logic [15:0] a, input logic [15:0] b, input logic rdy);
        byte_in(8'hAA);
        byte_in(a[15:8]);
        byte_in(a[7:0]);
        byte_in(b[15:8]);
        byte_in(b[7:0]);
        step(1'b1, 8'h55, 1'b0, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nb = 0; idle = 0;
        m_pa = 16'h0; m_pb = 16'h0;
        m_ok = 0; m_bad = 0; m_drop = 0;
        m_fv = 1'b0; m_err = 1'b0;
        check_all();
    endtask

    initial begin
        logic [7:0] fr [6];
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_ferr = 1'b0; engine_ready = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        // Good frame
        frame(16'h10AE, 16'h108B, 1'b1);
        chk("good_fv", {31'd0, frame_valid}, 32'd1);
        chk("good_pa", {16'd0, price_a}, 32'h10AE);
        chk("good_pb", {16'd0, price_b}, 32'h108B);
        chk("good_ok", 32'(cnt_ok), 32'd1);
        quiet(1);
        chk("good_inframe_low", {31'd0, in_frame}, 32'd0);

        // Back-pressure then a committing frame
        frame(16'h10AE, 16'h108B, 1'b0);
        chk("bp_fv", {31'd0, frame_valid}, 32'd0);
        chk("bp_drop", 32'(cnt_drop), 32'd1);
        frame(16'h1000, 16'h0FFF, 1'b1);
        chk("bp_next_pa", {16'd0, price_a}, 32'h1000);
        chk("bp_next_pb", {16'd0, price_b}, 32'h0FFF);

        // Bad footer equal to header resyncs
        byte_in(8'hAA); byte_in(8'h10); byte_in(8'hAE); byte_in(8'h10); byte_in(8'h8B);
        byte_in(8'hAA);
        chk("resync_err", {31'd0, err_pulse}, 32'd1);
        chk("resync_inframe", {31'd0, in_frame}, 32'd1);
        byte_in(8'h11); byte_in(8'h22); byte_in(8'h33); byte_in(8'h44); byte_in(8'h55);
        chk("resync_pa", {16'd0, price_a}, 32'h1122);
        chk("resync_pb", {16'd0, price_b}, 32'h3344);

        // Bad footer returns to hunt
        byte_in(8'hAA); byte_in(8'h01); byte_in(8'h02); byte_in(8'h03); byte_in(8'h04);
        byte_in(8'h00);
        chk("badftr_err", {31'd0, err_pulse}, 32'd1);
        chk("badftr_pa", {16'd0, price_a}, 32'h1122);

        // Timeout after silence, then a byte exactly at expiry
        byte_in(8'hAA); byte_in(8'h10);
        quiet(T);
        chk("timeout_err", {31'd0, err_pulse}, 32'd1);
        chk("timeout_hunt", {31'd0, in_frame}, 32'd0);
        byte_in(8'hAA); byte_in(8'h10);
        quiet(T - 1);
        byte_in(8'hAE);
        chk("expiry_byte_alive", {31'd0, in_frame}, 32'd1);
        chk("expiry_byte_noerr", {31'd0, err_pulse}, 32'd0);
        byte_in(8'h10); byte_in(8'h8B); byte_in(8'h55);
        chk("expiry_commit", {16'd0, price_a}, 32'h10AE);

        // Framing errors
        byte_in(8'hAA); byte_in(8'h10);
        step(1'b1, 8'hAE, 1'b1, 1'b1);
        chk("ferr_abort", {31'd0, err_pulse}, 32'd1);
        step(1'b1, 8'hAA, 1'b1, 1'b1);
        chk("ferr_hunt_ignored", {31'd0, err_pulse}, 32'd0);
        chk("ferr_hunt_nostart", {31'd0, in_frame}, 32'd0);

        // Drop counter saturation
        for (int i = 0; i < MAXC + 4; i++) frame(16'h1234, 16'h5678, 1'b0);
        chk("drop_saturated", 32'(cnt_drop), 32'(MAXC));

        // Reset while in B_HI, then a clean frame
        byte_in(8'hAA); byte_in(8'h12); byte_in(8'h34);
        do_reset();
        chk("rst_pa", {16'd0, price_a}, 32'd0);
        frame(16'hBEEF, 16'h0042, 1'b1);
        chk("post_rst_pa", {16'd0, price_a}, 32'hBEEF);

        // Randomized frames with corruption, gaps and back-pressure
        for (int it = 0; it < 300; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            fr[0] = 8'hAA;
            for (int j = 1; j < 5; j++) fr[j] = 8'($urandom);
            fr[5] = (kind == 1) ? 8'($urandom) : (kind == 2) ? 8'hAA : 8'h55;
            for (int j = 0; j < 6; j++) begin
                int g;
                if (j > 0) begin
                    if ($urandom_range(0, 9) == 0) g = T - 1 + int'($urandom_range(0, 2));
                    else g = int'($urandom_range(0, 2));
                    quiet(g);
                end
                step(1'b1, fr[j], ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0));
            end
        end
        quiet(T + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
